pcpu_mem_arbiter: RTL and testbench
===================================

Name: pcpu_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the pipeline's instruction fetch (IF) requester and memory-access (MA) requester.
- Sequences each access over a fixed memory latency and returns data with a one-cycle done pulse.
- Drives per-requester stall signals into the hazard logic and drops IF results that have been flushed.
- Sits between the pipeline stages and the unified memory in pcpu.

Parameters:
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4, number of consecutive MA grants with IF pending before IF is forced ahead once; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request; held until if_done or flush.
- if_addr  in  32  IF word address.
- if_flush  in  1  cancels the current or pending IF access.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction; 0 when if_done=0.
- ma_req  in  1  MA request; held until ma_done.
- ma_we  in  1  1=write, 0=read.
- ma_addr  in  32  MA address.
- ma_wdata  in  32  write data.
- ma_wstrb  in  4  byte enables for writes.
- ma_done  out  1  one-cycle pulse; access complete.
- ma_rdata  out  32  load data; 0 when ma_done=0.
- mem_en  out  1  memory command strobe; one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables; 0 on reads.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
- stall_if  out  1  if_req & ~if_done & ~if_flush.
- stall_ma  out  1  ma_req & ~ma_done.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State goes to IDLE; the latency counter, the starve counter and the kill flag clear.
  - All outputs are 0 except the stall terms, which are combinational from the inputs.
  - Reset during WAIT aborts the access; no done pulse follows.
- FSM with two states, IDLE and WAIT.
- IDLE, arbitration:
  - When STARVE_MAX has been reached and IF is eligible (if_req & ~if_flush), IF is granted.
  - Otherwise MA is granted if ma_req=1.
  - Otherwise IF is granted if it is eligible.
  - Otherwise the arbiter stays in IDLE.
- IDLE, grant cycle:
  - mem_en=1; mem_* are driven combinationally from the granted requester's inputs.
  - IF grants drive mem_we=0 and mem_wstrb=0.
  - The owner register is loaded, cnt<=MEM_LAT, and the next state is WAIT.
- Starve counter:
  - Increments on an MA grant while IF is eligible, saturating at STARVE_MAX.
  - Clears on any IF grant, and on an MA grant while IF is not eligible.
- WAIT:
  - mem_en=0; cnt decrements each cycle.
  - The cycle with cnt==1 is the done cycle: the owner's done pulse is 1 and its rdata = mem_rdata (writes return 0).
  - After the done cycle the next state is IDLE.
  - There is no grant in the done cycle, so throughput is 1 access per MEM_LAT+1 cycles.
- Requester rule: a requester may present a new request in the cycle after its done pulse. It is arbitrated then, so there is no double issue.
- Flush:
  - if_flush in IDLE blocks an IF grant that cycle.
  - if_flush during an IF-owned WAIT, including the done cycle, sets kill. With kill set, the arbiter still waits for the memory, but if_done=0 and if_rdata=0. Kill clears on entry to IDLE.
  - if_flush has no effect on an MA-owned access.
- Simultaneous if_req and ma_req with the starve count below STARVE_MAX: MA wins, because the older instruction goes first.
- A request dropping mid-WAIT is a protocol violation. The access still completes and the done pulse is issued.

Optional Feature:
- PCPU_ARB_TRACE_EN defined, simulation only:
  - On every grant, calls pcpu::log_msg with stage "ARB" and a message of "GNT IF" or "GNT MA", plus the address and R or W.
  - On every done, calls pcpu::log_data with stage "ARB", name "rdata" and the returned value.
  - A killed IF completion logs "KILL IF".
- PCPU_ARB_TRACE_EN undefined: no logging code is compiled and the RTL is identical otherwise.

Test Plan:
- MEM_LAT=2; single IF read, if_addr=0x100, memory word 0x00500093 → mem_en in cycle 0; if_done=1 and if_rdata=0x00500093 in cycle 2; IDLE in cycle 3.
- if_req and ma_req rise together, MA a read of 0x2000 returning 0xDEADBEEF → MA granted first; ma_done in cycle 2; IF granted in cycle 3; stall_if high in cycles 0–4.
- MA write with ma_addr=0x2004, ma_wdata=0x12345678, ma_wstrb=4'b0011 → exactly one mem_en with mem_we=1 and mem_wstrb=4'b0011; ma_done in cycle 2; ma_rdata=0.
- if_flush in cycle 1 of an IF access to 0x104 → no if_done; next grant in cycle 3; if_done never rises for 0x104.
- STARVE_MAX=4; ma_req held continuously with if_req held → grant order MA, MA, MA, MA, IF, MA...
- rstn pulled low in cycle 1 of an MA read → all outputs 0 immediately; no ma_done; after release the first grant occurs in the first cycle with a request.

Source files
------------

// File: rtl/pcpu_mem_arbiter.sv
// Shares one single-port synchronous memory between the pcpu IF and MA requesters.
// Optional simulation trace: define PCPU_ARB_TRACE_EN to log grants and completions.
module pcpu_mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ma_req,
    input  logic        ma_we,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    input  logic [3:0]  ma_wstrb,
    output logic        ma_done,
    output logic [31:0] ma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_ma
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] starve_r;
    logic       owner_ma_r;
    logic       write_r;
    logic       kill_r;
    logic       if_elig_s;
    logic       grant_if_s;
    logic       grant_ma_s;
    logic       done_s;

    // Arbitration and next-state decode
    always_comb begin
        state_nxt_s = state_r;
        grant_if_s  = 1'b0;
        grant_ma_s  = 1'b0;
        done_s      = 1'b0;
        if_elig_s   = if_req & ~if_flush;
        case (state_r)
            IDLE: begin
                // The starve override lets a long MA burst yield to IF exactly once
                if (!rstn) begin
                    state_nxt_s = IDLE;
                end else if ((starve_r == STARVE_C) && if_elig_s) begin
                    grant_if_s  = 1'b1;
                    state_nxt_s = WAIT;
                end else if (ma_req) begin
                    grant_ma_s  = 1'b1;
                    state_nxt_s = WAIT;
                end else if (if_elig_s) begin
                    grant_if_s  = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    done_s      = rstn;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Memory command and requester response outputs
    always_comb begin
        mem_en    = grant_if_s | grant_ma_s;
        mem_we    = grant_ma_s & ma_we;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (grant_ma_s) begin
            mem_addr = ma_addr;
            if (ma_we) begin
                mem_wdata = ma_wdata;
                mem_wstrb = ma_wstrb;
            end else begin
                mem_wdata = 32'd0;
                mem_wstrb = 4'd0;
            end
        end else if (grant_if_s) begin
            mem_addr = if_addr;
        end else begin
            mem_addr = 32'd0;
        end
        // A flush landing on the done cycle itself still suppresses the fetch
        if_done  = done_s & ~owner_ma_r & ~kill_r & ~if_flush;
        ma_done  = done_s & owner_ma_r;
        if_rdata = if_done ? mem_rdata : 32'd0;
        ma_rdata = (ma_done & ~write_r) ? mem_rdata : 32'd0;
        stall_if = if_req & ~if_done & ~if_flush;
        stall_ma = ma_req & ~ma_done;
    end

    // State, latency, starvation and kill registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            starve_r   <= 4'd0;
            owner_ma_r <= 1'b0;
            write_r    <= 1'b0;
            kill_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_if_s || grant_ma_s) begin
                cnt_r      <= LAT_C;
                owner_ma_r <= grant_ma_s;
                write_r    <= grant_ma_s & ma_we;
                kill_r     <= 1'b0;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 4'd1;
                if (done_s) begin
                    kill_r <= 1'b0;
                end else if (!owner_ma_r && if_flush) begin
                    kill_r <= 1'b1;
                end else begin
                    kill_r <= kill_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
            if (grant_if_s) begin
                starve_r <= 4'd0;
            end else if (grant_ma_s) begin
                if (!if_elig_s) begin
                    starve_r <= 4'd0;
                end else if (starve_r < STARVE_C) begin
                    starve_r <= starve_r + 4'd1;
                end else begin
                    starve_r <= starve_r;
                end
            end else begin
                starve_r <= starve_r;
            end
        end
    end

`ifdef PCPU_ARB_TRACE_EN
    // Simulation trace of grants and completions
    always_ff @(posedge clk) begin
        if (grant_if_s) begin
            pcpu::log_msg("ARB", $sformatf("GNT IF %08h R", if_addr));
        end else if (grant_ma_s) begin
            pcpu::log_msg("ARB", $sformatf("GNT MA %08h %s", ma_addr, ma_we ? "W" : "R"));
        end
        if (if_done) begin
            pcpu::log_data("ARB", "rdata", if_rdata);
        end else if (ma_done) begin
            pcpu::log_data("ARB", "rdata", ma_rdata);
        end else if (done_s && !owner_ma_r) begin
            pcpu::log_msg("ARB", "KILL IF");
        end
    end
`endif

endmodule

// File: tb/tb_pcpu_mem_arbiter.sv
// Self-checking bench for pcpu_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_pcpu_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, if_flush, ma_req, ma_we;
    logic [31:0] if_addr, ma_addr, ma_wdata;
    logic [3:0]  ma_wstrb;
    logic        if_done, ma_done, mem_en, mem_we, stall_if, stall_ma;
    logic [31:0] if_rdata, ma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcpu_mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_wstrb(ma_wstrb), .ma_done(ma_done), .ma_rdata(ma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_ma(stall_ma)
    );

    // Memory model: 4096 words, read data appears MEM_LAT cycles after the command
    logic [31:0] mem_arr [0:4095];
    logic [31:0] exp_mem [0:4095];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    bit          mem_ready;
    logic        cap_en, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;

    assign mem_rdata = rd_pipe[MEM_LAT-1];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        else if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
        else return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Capture the command mid-cycle so the memory never races the DUT at the edge
    always @(negedge clk) begin
        cap_en    <= mem_en;
        cap_we    <= mem_we;
        cap_addr  <= mem_addr;
        cap_wdata <= mem_wdata;
        cap_wstrb <= mem_wstrb;
    end

    // Memory array update and read-latency pipeline (garbage when not reading)
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= mem_init({18'd0, 12'(i), 2'b00});
            mem_ready <= 1'b1;
        end else if (cap_en && cap_we) begin
            mem_arr[cap_addr[13:2]] <= merge(mem_arr[cap_addr[13:2]], cap_wdata, cap_wstrb);
        end
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (cap_en && !cap_we) ? mem_arr[cap_addr[13:2]] : $urandom;
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_flush = 1'b0; if_addr = 32'd0;
        ma_req = 1'b0; ma_we = 1'b0; ma_addr = 32'd0; ma_wdata = 32'd0; ma_wstrb = 4'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 32'h0000_2000;
        ma_wdata = 32'hFFFF_FFFF; ma_wstrb = 4'hF;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_wstrb, if_done, ma_done} !== 8'd0)
            $display("FAIL reset_ctrl: got en=%b we=%b strb=%b ifd=%b mad=%b, want all 0",
                     mem_en, mem_we, mem_wstrb, if_done, ma_done);
        checks++;
        if ((mem_addr | mem_wdata | if_rdata | ma_rdata) !== 32'd0)
            $display("FAIL reset_data: got addr=%h wdata=%h ifr=%h mar=%h, want 0",
                     mem_addr, mem_wdata, if_rdata, ma_rdata);
        checks++;
        if ({stall_if, stall_ma} !== 2'b11)
            $display("FAIL reset_stall: got %b, want 11", {stall_if, stall_ma});
        errors += (({mem_en, mem_we, mem_wstrb, if_done, ma_done} !== 8'd0) ? 1 : 0)
                + (((mem_addr | mem_wdata | if_rdata | ma_rdata) !== 32'd0) ? 1 : 0)
                + (({stall_if, stall_ma} !== 2'b11) ? 1 : 0);
        idle_inputs();
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_if_read();
        logic        e_en, e_done;
        logic [31:0] e_addr, e_data;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if_req  = (c <= 5);
            if_addr = (c < 3) ? 32'h0000_0100 : 32'h0000_0104;
            e_en    = (c == 0) || (c == 3);
            e_addr  = (c == 0) ? 32'h0000_0100 : 32'h0000_0104;
            e_done  = (c == 2) || (c == 5);
            e_data  = (c == 2) ? 32'h0050_0093 : ((c == 5) ? mem_init(32'h0000_0104) : 32'd0);
            @(negedge clk);
            checks++;
            if (mem_en !== e_en || (e_en && (mem_addr !== e_addr || mem_we !== 1'b0 || mem_wstrb !== 4'd0))) begin
                errors++;
                $display("FAIL if_read_cmd c=%0d: got en=%b addr=%h we=%b strb=%b, want en=%b addr=%h we=0 strb=0",
                         c, mem_en, mem_addr, mem_we, mem_wstrb, e_en, e_addr);
            end
            checks++;
            if (if_done !== e_done || if_rdata !== e_data) begin
                errors++;
                $display("FAIL if_read_done c=%0d: got done=%b data=%h, want done=%b data=%h",
                         c, if_done, if_rdata, e_done, e_data);
            end
            checks++;
            if (stall_if !== (if_req && !e_done)) begin
                errors++;
                $display("FAIL if_read_stall c=%0d: got %b, want %b", c, stall_if, if_req && !e_done);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic        e_en, e_ifd, e_mad;
        logic [31:0] e_addr, e_ifr, e_mar;
        do_reset();
        if_addr = 32'h0000_0108;
        ma_addr = 32'h0000_2000;
        ma_we   = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if_req = (c <= 5);
            ma_req = (c <= 2);
            e_en   = (c == 0) || (c == 3);
            e_addr = (c == 0) ? 32'h0000_2000 : 32'h0000_0108;
            e_mad  = (c == 2);
            e_mar  = e_mad ? 32'hDEAD_BEEF : 32'd0;
            e_ifd  = (c == 5);
            e_ifr  = e_ifd ? mem_init(32'h0000_0108) : 32'd0;
            @(negedge clk);
            checks++;
            if (mem_en !== e_en || (e_en && mem_addr !== e_addr)) begin
                errors++;
                $display("FAIL simul_cmd c=%0d: got en=%b addr=%h, want en=%b addr=%h",
                         c, mem_en, mem_addr, e_en, e_addr);
            end
            checks++;
            if (ma_done !== e_mad || ma_rdata !== e_mar || if_done !== e_ifd || if_rdata !== e_ifr) begin
                errors++;
                $display("FAIL simul_done c=%0d: got mad=%b mar=%h ifd=%b ifr=%h, want mad=%b mar=%h ifd=%b ifr=%h",
                         c, ma_done, ma_rdata, if_done, if_rdata, e_mad, e_mar, e_ifd, e_ifr);
            end
            checks++;
            if (stall_if !== (c <= 4) || stall_ma !== (c <= 1)) begin
                errors++;
                $display("FAIL simul_stall c=%0d: got if=%b ma=%b, want if=%b ma=%b",
                         c, stall_if, stall_ma, c <= 4, c <= 1);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_ma_write();
        int          en_count;
        logic [31:0] e_word;
        do_reset();
        en_count = 0;
        e_word   = merge(mem_init(32'h0000_2004), 32'h1234_5678, 4'b0011);
        ma_we = 1'b1; ma_addr = 32'h0000_2004; ma_wdata = 32'h1234_5678; ma_wstrb = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            ma_req = (c <= 2);
            @(negedge clk);
            if (mem_en) en_count++;
            if (c == 0) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011 ||
                    mem_addr !== 32'h0000_2004 || mem_wdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL ma_write_cmd: got en=%b we=%b strb=%b addr=%h wdata=%h, want 1 1 0011 00002004 12345678",
                             mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata);
                end
            end
            checks++;
            if (ma_done !== (c == 2) || ma_rdata !== 32'd0) begin
                errors++;
                $display("FAIL ma_write_done c=%0d: got done=%b rdata=%h, want done=%b rdata=0",
                         c, ma_done, ma_rdata, c == 2);
            end
            next_cycle();
        end
        checks++;
        if (en_count != 1) begin
            errors++;
            $display("FAIL ma_write_en_count: got %0d, want 1", en_count);
        end
        ma_we = 1'b0; ma_wstrb = 4'd0;
        for (int c = 0; c < 4; c++) begin
            ma_req = (c <= 2);
            @(negedge clk);
            checks++;
            if (ma_done !== (c == 2) || ma_rdata !== ((c == 2) ? e_word : 32'd0)) begin
                errors++;
                $display("FAIL ma_readback c=%0d: got done=%b rdata=%h, want done=%b rdata=%h",
                         c, ma_done, ma_rdata, c == 2, (c == 2) ? e_word : 32'd0);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        logic        e_en, e_done, e_stall;
        logic [31:0] e_addr;
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0104; if_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_block: got en=%b stall=%b, want en=0 stall=0", mem_en, stall_if);
        end
        next_cycle();
        for (int c = 0; c < 7; c++) begin
            if_req   = (c <= 1) || (c >= 3 && c <= 5);
            if_addr  = (c <= 1) ? 32'h0000_0104 : 32'h0000_0108;
            if_flush = (c == 1);
            e_en     = (c == 0) || (c == 3);
            e_addr   = (c == 0) ? 32'h0000_0104 : 32'h0000_0108;
            e_done   = (c == 5);
            e_stall  = (c == 0) || (c == 3) || (c == 4);
            @(negedge clk);
            checks++;
            if (mem_en !== e_en || (e_en && mem_addr !== e_addr)) begin
                errors++;
                $display("FAIL flush_cmd c=%0d: got en=%b addr=%h, want en=%b addr=%h",
                         c, mem_en, mem_addr, e_en, e_addr);
            end
            checks++;
            if (if_done !== e_done || if_rdata !== (e_done ? mem_init(32'h0000_0108) : 32'd0)) begin
                errors++;
                $display("FAIL flush_done c=%0d: got done=%b data=%h, want done=%b",
                         c, if_done, if_rdata, e_done);
            end
            checks++;
            if (stall_if !== e_stall) begin
                errors++;
                $display("FAIL flush_stall c=%0d: got %b, want %b", c, stall_if, e_stall);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_starve();
        int   n;
        logic is_ma, e_ma;
        do_reset();
        n = 0;
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 32'h0000_3000;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge clk);
            if (mem_en) begin
                is_ma = (mem_addr == 32'h0000_3000);
                e_ma  = !(n == 4 || n == 9);
                checks++;
                if (is_ma !== e_ma) begin
                    errors++;
                    $display("FAIL starve_order grant=%0d: got %s, want %s", n,
                             is_ma ? "MA" : "IF", e_ma ? "MA" : "IF");
                end
                n++;
            end
            next_cycle();
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL starve_timeout: got %0d grants, want 10", n);
        end
        idle_inputs();
        repeat (MEM_LAT + 2) next_cycle();
    endtask

    task automatic test_reset_mid();
        logic e_en, e_done;
        do_reset();
        ma_we = 1'b0; ma_addr = 32'h0000_2000;
        for (int c = 0; c < 7; c++) begin
            rstn   = (c != 1);
            ma_req = (c <= 1) || (c >= 4);
            e_en   = (c == 0) || (c == 4);
            e_done = (c == 6);
            @(negedge clk);
            checks++;
            if (mem_en !== e_en || (e_en && mem_addr !== 32'h0000_2000)) begin
                errors++;
                $display("FAIL rst_mid_cmd c=%0d: got en=%b addr=%h, want en=%b", c, mem_en, mem_addr, e_en);
            end
            checks++;
            if (ma_done !== e_done || ma_rdata !== (e_done ? 32'hDEAD_BEEF : 32'd0)) begin
                errors++;
                $display("FAIL rst_mid_done c=%0d: got done=%b data=%h, want done=%b", c, ma_done, ma_rdata, e_done);
            end
            if (c == 1) begin
                checks++;
                if ((mem_addr | mem_wdata | if_rdata) !== 32'd0 || {mem_we, mem_wstrb, if_done} !== 6'd0 ||
                    stall_ma !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: got addr=%h we=%b strb=%b ifd=%b stall_ma=%b, want 0 0 0 0 1",
                             mem_addr, mem_we, mem_wstrb, if_done, stall_ma);
                end
            end
            next_cycle();
        end
        rstn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_random();
        int          done_cyc, free_cyc, starve;
        bit          cur_ma, cur_wr, killed, if_act, ma_act, if_elig, gi, gm;
        logic        e_en, e_we, e_ifd, e_mad, e_sif, e_sma;
        logic [31:0] e_addr, e_wdata, e_ifr, e_mar, cur_data;
        logic [3:0]  e_wstrb;
        do_reset();
        for (int i = 0; i < 4096; i++) exp_mem[i] = mem_arr[i];
        done_cyc = -1; free_cyc = 0; starve = 0;
        cur_ma = 1'b0; cur_wr = 1'b0; killed = 1'b0; if_act = 1'b0; ma_act = 1'b0;
        cur_data = 32'd0;
        for (int t = 0; t < 1500; t++) begin
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act  = 1'b1;
                if_addr = {18'd0, 12'($urandom), 2'b00};
            end
            if (!ma_act && $urandom_range(0, 2) == 0) begin
                ma_act   = 1'b1;
                ma_addr  = {18'd0, 12'($urandom), 2'b00};
                ma_we    = 1'($urandom_range(0, 1));
                ma_wdata = $urandom;
                ma_wstrb = 4'($urandom);
            end
            if_req   = if_act;
            ma_req   = ma_act;
            if_flush = ($urandom_range(0, 9) == 0);

            e_en = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_wstrb = 4'd0;
            e_ifd = 1'b0; e_mad = 1'b0; e_ifr = 32'd0; e_mar = 32'd0;
            if_elig = if_act && !if_flush;
            if (t == done_cyc) begin
                if (cur_ma) begin
                    e_mad = 1'b1;
                    e_mar = cur_wr ? 32'd0 : cur_data;
                end else if (!killed && !if_flush) begin
                    e_ifd = 1'b1;
                    e_ifr = cur_data;
                end
            end else if (t >= free_cyc) begin
                gi = (starve == STARVE_MAX) && if_elig;
                gm = !gi && ma_act;
                if (!gi && !gm) gi = if_elig;
                if (gi || gm) begin
                    e_en = 1'b1; killed = 1'b0; cur_ma = gm;
                    done_cyc = t + MEM_LAT; free_cyc = done_cyc + 1;
                    if (gm) begin
                        e_addr = ma_addr; e_we = ma_we; cur_wr = ma_we;
                        if (ma_we) begin
                            e_wstrb = ma_wstrb; e_wdata = ma_wdata;
                            exp_mem[ma_addr[13:2]] = merge(exp_mem[ma_addr[13:2]], ma_wdata, ma_wstrb);
                        end else begin
                            cur_data = exp_mem[ma_addr[13:2]];
                        end
                        starve = !if_elig ? 0 : ((starve < STARVE_MAX) ? starve + 1 : starve);
                    end else begin
                        e_addr = if_addr; cur_wr = 1'b0;
                        cur_data = exp_mem[if_addr[13:2]];
                        starve = 0;
                    end
                end
            end else if (!cur_ma && if_flush) begin
                killed = 1'b1;
            end
            e_sif = if_act && !e_ifd && !if_flush;
            e_sma = ma_act && !e_mad;

            @(negedge clk);
            checks++;
            if (mem_en !== e_en || (e_en && (mem_addr !== e_addr || mem_we !== e_we ||
                mem_wstrb !== e_wstrb || (e_we && mem_wdata !== e_wdata)))) begin
                errors++;
                $display("FAIL rand_cmd t=%0d: got en=%b addr=%h we=%b strb=%b wd=%h, want en=%b addr=%h we=%b strb=%b wd=%h",
                         t, mem_en, mem_addr, mem_we, mem_wstrb, mem_wdata, e_en, e_addr, e_we, e_wstrb, e_wdata);
            end
            checks++;
            if (if_done !== e_ifd || if_rdata !== e_ifr) begin
                errors++;
                $display("FAIL rand_if t=%0d: got done=%b data=%h, want done=%b data=%h",
                         t, if_done, if_rdata, e_ifd, e_ifr);
            end
            checks++;
            if (ma_done !== e_mad || ma_rdata !== e_mar) begin
                errors++;
                $display("FAIL rand_ma t=%0d: got done=%b data=%h, want done=%b data=%h",
                         t, ma_done, ma_rdata, e_mad, e_mar);
            end
            checks++;
            if (stall_if !== e_sif || stall_ma !== e_sma) begin
                errors++;
                $display("FAIL rand_stall t=%0d: got if=%b ma=%b, want if=%b ma=%b",
                         t, stall_if, stall_ma, e_sif, e_sma);
            end
            if (e_ifd || if_flush) if_act = 1'b0;
            if (e_mad) ma_act = 1'b0;
            next_cycle();
        end
        idle_inputs();
        repeat (MEM_LAT + 2) next_cycle();
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        next_cycle();
        next_cycle();
        test_reset();
        test_if_read();
        test_simultaneous();
        test_ma_write();
        test_flush();
        test_starve();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
